// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux scan controller and its settle counter.
package mux_scan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int NCH  = 8;
   localparam int SELW = 3;
   localparam int CNTW = 4;

endpackage

// File: rtl/mux_scan_cnt.sv
// Settle counter: counts cycles a mux select has been held, flags the sampling cycle.
module mux_scan_cnt
   import mux_scan_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [CNTW-1:0] cnt;

   // Clear has priority so the sampling edge can restart the count for the next channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == CNTW'(SETTLE - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans an external 8:1 mux channel by channel and captures one bit per channel.
// Define SCAN_PARITY_EN to add a registered parity output over the captured word.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            y_in,
   output logic [SELW-1:0] sel,
   output logic            busy,
   output logic            done,
   output logic [NCH-1:0]  data
`ifdef SCAN_PARITY_EN
   ,
   output logic            parity
`endif
);

   state_t          state;
   state_t          state_nxt;
   logic [SELW-1:0] sel_nxt;
   logic [NCH-1:0]  cap;
   logic [NCH-1:0]  cap_nxt;
   logic [NCH-1:0]  data_nxt;
   logic            done_nxt;
   logic            cnt_clr;
   logic            cnt_inc;
   logic            cnt_tc;

   mux_scan_cnt #(
      .SETTLE(SETTLE)
   ) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(cnt_clr),
      .inc(cnt_inc),
      .tc (cnt_tc)
   );

   assign busy = (state == SCAN);

   // On the last channel, a start seen on the same edge restarts immediately so
   // back-to-back scans complete exactly 8*SETTLE cycles apart.
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      cap_nxt   = cap;
      data_nxt  = data;
      done_nxt  = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SCAN;
               sel_nxt   = '0;
               cnt_clr   = 1'b1;
            end
         end
         SCAN: begin
            if (cnt_tc) begin
               cnt_clr      = 1'b1;
               cap_nxt[sel] = y_in;
               if (sel != SELW'(NCH - 1)) begin
                  sel_nxt = sel + 1'b1;
               end else begin
                  data_nxt  = cap_nxt;
                  done_nxt  = 1'b1;
                  sel_nxt   = '0;
                  state_nxt = start ? SCAN : IDLE;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sel   <= '0;
         cap   <= '0;
         data  <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         cap   <= cap_nxt;
         data  <= data_nxt;
         done  <= done_nxt;
      end
   end

`ifdef SCAN_PARITY_EN
   // Parity tracks the published word, so it only moves when data does.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity <= 1'b0;
      end else if (done_nxt) begin
         parity <= ^data_nxt;
      end
   end
`endif

endmodule
